// File: rtl/uart_mem_arbiter.sv
// rtl/uart_mem_arbiter.sv - N-channel UART receive/transmit arbiter sharing the CPU data-memory port
`ifndef DATA_MEM_ADDR_SIZE
`define DATA_MEM_ADDR_SIZE 12
`endif

module uart_mem_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = `DATA_MEM_ADDR_SIZE,
    parameter int UART_BASE   = 'h7F0,
    parameter int STAT_BASE   = 'h7F8,
    parameter int RXBUF_BASE  = 'h800,
    parameter int RXBUF_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     cpuAddress,
    input  logic                  cpuMemRead,
    input  logic                  cpuMemWrite,
    input  logic [7:0]            cpuWriteData,
    output logic [7:0]            cpuReadData,
    output logic                  cpuStall,
    output logic [ADDR_W-1:0]     memAddress,
    output logic [7:0]            memWriteData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [7:0]            memReadData,
    input  logic [NUM_CH-1:0]     rxReady,
    input  logic [NUM_CH*8-1:0]   rxData,
    output logic [NUM_CH-1:0]     rxClear,
    input  logic [NUM_CH-1:0]     txBusy,
    output logic [NUM_CH-1:0]     txEnable,
    output logic [7:0]            txData
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (RXBUF_DEPTH > 1) ? $clog2(RXBUF_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] UART_LO = ADDR_W'(UART_BASE);
    localparam logic [ADDR_W-1:0] STAT_LO = ADDR_W'(STAT_BASE);
    localparam logic [ADDR_W-1:0] NCH_A   = ADDR_W'(NUM_CH);
    localparam logic [6:0]        DEPTH_C = 7'(RXBUF_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(RXBUF_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WRITE, RECOVER} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_ch;
    logic [7:0]        gnt_byte;
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [6:0]        count [NUM_CH];
    logic [6:0]        count_nxt [NUM_CH];
    logic [NUM_CH-1:0] overflow;

    logic [ADDR_W-1:0] uart_off, stat_off, ring_addr;
    logic [CH_W-1:0]   uart_ch, stat_ch, next_ch;
    logic [6:0]        ack_n;
    logic              uart_hit, stat_hit, cpu_mem, tx_req, tx_go, ack;
    logic              ring_write, rx_done, rx_drop;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
        int idx;
        idx = int'(base) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        return CH_W'(idx);
    endfunction

    // Unsigned offset compare: addresses below a base wrap to large values and miss.
    assign uart_off = cpuAddress - UART_LO;
    assign stat_off = cpuAddress - STAT_LO;
    assign uart_hit = uart_off < NCH_A;
    assign stat_hit = stat_off < NCH_A;
    assign uart_ch  = uart_off[CH_W-1:0];
    assign stat_ch  = stat_off[CH_W-1:0];
    assign ack_n    = {1'b0, cpuWriteData[5:0]};

    assign cpu_mem  = reset_n & (cpuMemRead | cpuMemWrite) & ~uart_hit & ~stat_hit;
    assign tx_req   = reset_n & cpuMemWrite & uart_hit;
    assign tx_go    = tx_req & ~txBusy[uart_ch];
    assign cpuStall = tx_req & txBusy[uart_ch];
    assign ack      = reset_n & cpuMemWrite & stat_hit;

    assign rx_done    = (state == WRITE) & ~cpu_mem;
    assign ring_write = rx_done & (count[gnt_ch] < DEPTH_C);
    assign rx_drop    = rx_done & ~ring_write;
    assign ring_addr  = ADDR_W'(RXBUF_BASE + int'(gnt_ch) * RXBUF_DEPTH + int'(wr_ptr[gnt_ch]));
    assign rxClear    = rx_done ? (NUM_CH'(1) << gnt_ch) : '0;

    always_comb begin
        next_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rxReady[rr_idx(rr_ptr, k)]) next_ch = rr_idx(rr_ptr, k);
        end
    end

    always_comb begin
        cpuReadData = 8'h00;
        if (reset_n && cpuMemRead) begin
            if (stat_hit)
                cpuReadData = {overflow[stat_ch], 1'b0, count[stat_ch][5:0]};
            else if (!uart_hit)
                cpuReadData = memReadData;
        end
    end

    always_comb begin
        memAddress   = '0;
        memWriteData = 8'h00;
        memWrite     = 1'b0;
        memRead      = 1'b0;
        if (cpu_mem) begin
            memAddress   = cpuAddress;
            memWriteData = cpuWriteData;
            memWrite     = cpuMemWrite;
            memRead      = cpuMemRead;
        end else if (ring_write) begin
            memAddress   = ring_addr;
            memWriteData = gnt_byte;
            memWrite     = 1'b1;
        end
    end

    // The ack is bounded by the pre-increment count, so the result can never wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_nxt[i] = count[i];
            if (ring_write && gnt_ch == CH_W'(i))
                count_nxt[i] = count_nxt[i] + 7'd1;
            if (ack && stat_ch == CH_W'(i))
                count_nxt[i] = count_nxt[i] - ((ack_n < count[i]) ? ack_n : count[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_ch   <= '0;
            gnt_byte <= 8'h00;
            overflow <= '0;
            txData   <= 8'h00;
            txEnable <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            txEnable <= '0;
            if (tx_go) begin
                txEnable <= NUM_CH'(1) << uart_ch;
                txData   <= cpuWriteData;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= count_nxt[i];
                if (ack && stat_ch == CH_W'(i) && cpuWriteData[7])
                    overflow[i] <= 1'b0;
                if (rx_drop && gnt_ch == CH_W'(i))
                    overflow[i] <= 1'b1;
            end

            if (ring_write)
                wr_ptr[gnt_ch] <= (wr_ptr[gnt_ch] == PTR_MAX) ? '0 : wr_ptr[gnt_ch] + PTR_W'(1);

            case (state)
                IDLE: begin
                    if (|rxReady) begin
                        gnt_ch   <= next_ch;
                        gnt_byte <= rxData[int'(next_ch) * 8 +: 8];
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (rx_done) begin
                        rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
                        state  <= RECOVER;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_arbiter.sv
// tb/tb_uart_mem_arbiter.sv - directed vector bench for uart_mem_arbiter
module tb_uart_mem_arbiter;
    logic        clk;
    logic        reset_n;
    logic [11:0] cpuAddress;
    logic        cpuMemRead, cpuMemWrite;
    logic [7:0]  cpuWriteData, cpuReadData;
    logic        cpuStall;
    logic [11:0] memAddress;
    logic [7:0]  memWriteData, memReadData;
    logic        memWrite, memRead;
    logic [1:0]  rxReady, rxClear, txBusy, txEnable;
    logic [15:0] rxData;
    logic [7:0]  txData;

    int passed = 0;
    int total  = 0;

    uart_mem_arbiter #(.NUM_CH(2), .ADDR_W(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpuAddress(cpuAddress), .cpuMemRead(cpuMemRead), .cpuMemWrite(cpuMemWrite),
        .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData), .cpuStall(cpuStall),
        .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
        .memRead(memRead), .memReadData(memReadData),
        .rxReady(rxReady), .rxData(rxData), .rxClear(rxClear),
        .txBusy(txBusy), .txEnable(txEnable), .txData(txData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    typedef struct {
        logic [11:0] addr;
        logic        rd, wr;
        logic [7:0]  wdata, mrdata;
        logic [1:0]  busy;
        logic [11:0] e_maddr;
        logic        e_mwr, e_mrd;
        logic [7:0]  e_mwdata, e_rdata;
        logic        e_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cpu_idle();
        cpuMemRead = 1'b0; cpuMemWrite = 1'b0;
        cpuAddress = 12'h000; cpuWriteData = 8'h00; memReadData = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cpu_idle();
        rxReady = 2'b00; rxData = 16'h0000; txBusy = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic read_stat(input int ch, input logic [7:0] exp);
        @(negedge clk);
        cpuAddress = 12'(12'h7F8 + ch); cpuMemRead = 1'b1;
        #1;
        check("stat_read", 32'(cpuReadData), 32'(exp));
        check("stat_no_memread", 32'(memRead), 32'(0));
        @(negedge clk);
        cpuMemRead = 1'b0;
    endtask

    task automatic cpu_store(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        cpuAddress = a; cpuWriteData = d; cpuMemWrite = 1'b1;
        @(negedge clk);
        cpuMemWrite = 1'b0;
    endtask

    task automatic send_rx(input int ch, input logic [7:0] b, input logic exp_wr, input logic [11:0] exp_addr);
        @(negedge clk);
        rxReady[ch] = 1'b1; rxData[8*ch +: 8] = b;
        @(negedge clk); #1;
        check("rx_memWrite", 32'(memWrite), 32'(exp_wr));
        if (exp_wr) begin
            check("rx_memAddress", 32'(memAddress), 32'(exp_addr));
            check("rx_memWriteData", 32'(memWriteData), 32'(b));
        end
        check("rx_clear", 32'(rxClear), 32'(2'(1 << ch)));
        @(negedge clk);
        rxReady[ch] = 1'b0;
        #1 check("rx_clear_one_cycle", 32'(rxClear), 32'(0));
    endtask

    logic [11:0] rr_addr[4] = '{12'h800, 12'h810, 12'h801, 12'h811};
    logic [7:0]  rr_data[4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    logic [1:0]  rr_clr[4]  = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        //           addr    rd wr wdata  mrdata busy  e_maddr e_mwr e_mrd e_mwdata e_rdata e_stall
        vecs[0] = '{12'h100, 1, 0, 8'h00, 8'hA5, 2'b00, 12'h100, 0, 1, 8'h00, 8'hA5, 0};
        vecs[1] = '{12'h123, 0, 1, 8'h3C, 8'h00, 2'b00, 12'h123, 1, 0, 8'h3C, 8'h00, 0};
        vecs[2] = '{12'h7F0, 1, 0, 8'h00, 8'h77, 2'b00, 12'h000, 0, 0, 8'h00, 8'h00, 0};
        vecs[3] = '{12'h7F8, 1, 0, 8'h00, 8'h77, 2'b00, 12'h000, 0, 0, 8'h00, 8'h00, 0};
        vecs[4] = '{12'h7F9, 1, 0, 8'h00, 8'h66, 2'b00, 12'h000, 0, 0, 8'h00, 8'h00, 0};
        vecs[5] = '{12'h7F2, 1, 0, 8'h00, 8'h5E, 2'b00, 12'h7F2, 0, 1, 8'h00, 8'h5E, 0};
        vecs[6] = '{12'h7FA, 1, 0, 8'h00, 8'h11, 2'b00, 12'h7FA, 0, 1, 8'h00, 8'h11, 0};
        vecs[7] = '{12'h7EF, 1, 0, 8'h00, 8'h22, 2'b00, 12'h7EF, 0, 1, 8'h00, 8'h22, 0};
        vecs[8] = '{12'h7F1, 0, 1, 8'h99, 8'h00, 2'b10, 12'h000, 0, 0, 8'h00, 8'h00, 1};
        vecs[9] = '{12'h7F2, 0, 1, 8'h44, 8'h00, 2'b00, 12'h7F2, 1, 0, 8'h44, 8'h00, 0};

        reset_n = 1'b0;
        cpu_idle();
        rxReady = 2'b00; rxData = 16'h0000; txBusy = 2'b00;
        cpuAddress = 12'h100; cpuMemRead = 1'b1; memReadData = 8'hA5;
        #1;
        check("reset_memRead", 32'(memRead), 32'(0));
        check("reset_cpuReadData", 32'(cpuReadData), 32'(0));
        check("reset_txEnable", 32'(txEnable), 32'(0));
        check("reset_txData", 32'(txData), 32'(0));
        check("reset_rxClear", 32'(rxClear), 32'(0));
        @(negedge clk);
        cpu_idle();
        reset_n = 1'b1;
        read_stat(0, 8'h00);
        read_stat(1, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            cpuAddress = vecs[i].addr; cpuMemRead = vecs[i].rd; cpuMemWrite = vecs[i].wr;
            cpuWriteData = vecs[i].wdata; memReadData = vecs[i].mrdata; txBusy = vecs[i].busy;
            #1;
            check("vec_memWrite", 32'(memWrite), 32'(vecs[i].e_mwr));
            check("vec_memRead", 32'(memRead), 32'(vecs[i].e_mrd));
            check("vec_cpuStall", 32'(cpuStall), 32'(vecs[i].e_stall));
            if (vecs[i].rd) check("vec_cpuReadData", 32'(cpuReadData), 32'(vecs[i].e_rdata));
            if (vecs[i].e_mwr || vecs[i].e_mrd)
                check("vec_memAddress", 32'(memAddress), 32'(vecs[i].e_maddr));
            if (vecs[i].e_mwr)
                check("vec_memWriteData", 32'(memWriteData), 32'(vecs[i].e_mwdata));
        end
        @(negedge clk);
        cpu_idle(); txBusy = 2'b00;
        #1 check("vec_no_tx_while_busy", 32'(txEnable), 32'(0));

        // reset asserted while a byte is being written
        @(negedge clk);
        rxReady[0] = 1'b1; rxData[7:0] = 8'h55;
        @(negedge clk); #1;
        check("rst_pre_clear", 32'(rxClear), 32'(2'b01));
        reset_n = 1'b0;
        #1;
        check("rst_clear_dropped", 32'(rxClear), 32'(0));
        check("rst_write_dropped", 32'(memWrite), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("rst_regrant_write", 32'(memWrite), 32'(1));
        check("rst_regrant_addr", 32'(memAddress), 32'(12'h800));
        check("rst_regrant_data", 32'(memWriteData), 32'(8'h55));
        check("rst_regrant_clear", 32'(rxClear), 32'(2'b01));
        @(negedge clk);
        rxReady = 2'b00;

        do_reset();
        send_rx(0, 8'h41, 1'b1, 12'h800);
        read_stat(0, 8'h01);
        cpu_store(12'h7F8, 8'h01);
        read_stat(0, 8'h00);

        do_reset();
        @(negedge clk);
        rxReady = 2'b11; rxData = {8'hB0, 8'hA0};
        for (int j = 0; j < 4; j++) begin
            logic found;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk); #1;
                if (memWrite) found = 1'b1;
            end
            check("rr_write_seen", 32'(found), 32'(1));
            check("rr_addr", 32'(memAddress), 32'(rr_addr[j]));
            check("rr_data", 32'(memWriteData), 32'(rr_data[j]));
            check("rr_clear", 32'(rxClear), 32'(rr_clr[j]));
            if (rr_clr[j] == 2'b01) rxData[7:0] = 8'hA1;
            else rxData[15:8] = 8'hB1;
        end
        @(negedge clk);
        rxReady = 2'b00;

        // CPU memory store collides with the ring write
        do_reset();
        @(negedge clk);
        rxReady[0] = 1'b1; rxData[7:0] = 8'h66;
        @(negedge clk);
        cpuAddress = 12'h100; cpuWriteData = 8'h99; cpuMemWrite = 1'b1;
        #1;
        check("prio_cpu_addr", 32'(memAddress), 32'(12'h100));
        check("prio_cpu_data", 32'(memWriteData), 32'(8'h99));
        check("prio_cpu_write", 32'(memWrite), 32'(1));
        check("prio_no_clear", 32'(rxClear), 32'(0));
        @(negedge clk);
        cpu_idle();
        #1;
        check("prio_rx_write", 32'(memWrite), 32'(1));
        check("prio_rx_addr", 32'(memAddress), 32'(12'h800));
        check("prio_rx_data", 32'(memWriteData), 32'(8'h66));
        check("prio_rx_clear", 32'(rxClear), 32'(2'b01));
        @(negedge clk);
        rxReady = 2'b00;
        #1 check("prio_done", 32'(memWrite), 32'(0));
        read_stat(0, 8'h01);

        // ack landing in the same cycle as an increment
        send_rx(0, 8'h67, 1'b1, 12'h801);
        @(negedge clk);
        rxReady[0] = 1'b1; rxData[7:0] = 8'h68;
        @(negedge clk);
        cpuAddress = 12'h7F8; cpuWriteData = 8'h02; cpuMemWrite = 1'b1;
        #1;
        check("ackinc_write", 32'(memWrite), 32'(1));
        check("ackinc_addr", 32'(memAddress), 32'(12'h802));
        check("ackinc_clear", 32'(rxClear), 32'(2'b01));
        @(negedge clk);
        cpu_idle(); rxReady = 2'b00;
        read_stat(0, 8'h01);

        do_reset();
        for (int k = 0; k < 16; k++)
            send_rx(0, 8'(8'h10 + k), 1'b1, 12'(12'h800 + k));
        send_rx(0, 8'hEE, 1'b0, 12'h000);
        read_stat(0, 8'h90);
        read_stat(1, 8'h00);
        cpu_store(12'h7F8, 8'h90);
        read_stat(0, 8'h00);
        send_rx(0, 8'h21, 1'b1, 12'h800);

        // transmit stalled by a busy channel, then a free one
        @(negedge clk);
        txBusy = 2'b10;
        cpuAddress = 12'h7F1; cpuWriteData = 8'h5A; cpuMemWrite = 1'b1;
        #1;
        check("tx_stall", 32'(cpuStall), 32'(1));
        check("tx_stall_no_mem", 32'(memWrite), 32'(0));
        @(negedge clk); #1;
        check("tx_stall_hold", 32'(cpuStall), 32'(1));
        check("tx_no_enable_busy", 32'(txEnable), 32'(0));
        txBusy = 2'b00;
        #1 check("tx_stall_release", 32'(cpuStall), 32'(0));
        @(negedge clk);
        cpu_idle();
        #1;
        check("tx_enable", 32'(txEnable), 32'(2'b10));
        check("tx_data", 32'(txData), 32'(8'h5A));
        @(negedge clk); #1;
        check("tx_enable_one_cycle", 32'(txEnable), 32'(0));
        cpuAddress = 12'h7F0; cpuWriteData = 8'hC3; cpuMemWrite = 1'b1;
        #1 check("tx0_no_stall", 32'(cpuStall), 32'(0));
        @(negedge clk);
        cpu_idle();
        #1;
        check("tx0_enable", 32'(txEnable), 32'(2'b01));
        check("tx0_data", 32'(txData), 32'(8'hC3));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
